// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor: round toward zero, denormals flushed on input and output.
// Stage 1 unpacks/classifies/swaps, stage 2 aligns and adds, stage 3 normalises and packs.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    output logic [EXP_W+MAN_W:0] sum
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned MW   = MAN_W + 1;          // mantissa with hidden bit
    localparam int unsigned AW   = MAN_W + 4;          // plus guard, round, sticky
    localparam int unsigned SW   = AW + 1;             // plus carry out
    localparam int unsigned EW   = EXP_W + 2;          // signed exponent headroom
    localparam int unsigned LZW  = $clog2(AW + 1);
    localparam int unsigned EMAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ---------------- Stage 1: unpack, classify, order by magnitude
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_man, w_b_man;
    logic             w_a_sign, w_b_sign, w_a_zero, w_b_zero;
    logic             w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [W-2:0]     w_a_key, w_b_key, w_x_key, w_y_key;
    logic             w_swap, w_nan, w_inf, w_inf_sign;

    assign w_a_exp  = a[W-2:MAN_W];
    assign w_b_exp  = b[W-2:MAN_W];
    assign w_a_man  = a[MAN_W-1:0];
    assign w_b_man  = b[MAN_W-1:0];
    assign w_a_sign = a[W-1];
    assign w_b_sign = b[W-1] ^ sub;
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (&w_a_exp) && (w_a_man == '0);
    assign w_b_inf  = (&w_b_exp) && (w_b_man == '0);
    assign w_a_nan  = (&w_a_exp) && (|w_a_man);
    assign w_b_nan  = (&w_b_exp) && (|w_b_man);
    // Denormals become zero magnitude, so they sort and add as zeros
    assign w_a_key  = w_a_zero ? '0 : a[W-2:0];
    assign w_b_key  = w_b_zero ? '0 : b[W-2:0];
    assign w_swap   = (w_b_key > w_a_key);
    assign w_x_key  = w_swap ? w_b_key : w_a_key;
    assign w_y_key  = w_swap ? w_a_key : w_b_key;
    assign w_nan    = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sign ^ w_b_sign));
    assign w_inf    = w_a_inf || w_b_inf;
    assign w_inf_sign = w_a_inf ? w_a_sign : w_b_sign;

    logic             r1_valid, r1_x_sign, r1_op, r1_special;
    logic [EXP_W-1:0] r1_x_exp, r1_diff;
    logic [MW-1:0]    r1_x_man, r1_y_man;
    logic [W-1:0]     r1_spec_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r1_x_sign   <= 1'b0;
            r1_op       <= 1'b0;
            r1_special  <= 1'b0;
            r1_x_exp    <= '0;
            r1_diff     <= '0;
            r1_x_man    <= '0;
            r1_y_man    <= '0;
            r1_spec_val <= '0;
        end else begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_x_sign   <= w_swap ? w_b_sign : w_a_sign;
                r1_op       <= w_a_sign ^ w_b_sign;
                r1_special  <= w_nan || w_inf;
                r1_x_exp    <= w_x_key[W-2:MAN_W];
                r1_diff     <= w_x_key[W-2:MAN_W] - w_y_key[W-2:MAN_W];
                r1_x_man    <= {|w_x_key[W-2:MAN_W], w_x_key[MAN_W-1:0]};
                r1_y_man    <= {|w_y_key[W-2:MAN_W], w_y_key[MAN_W-1:0]};
                r1_spec_val <= w_nan ? QNAN : {w_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end
    end

    // ---------------- Stage 2: align Y with guard/round/sticky, add or subtract
    logic [AW-1:0] w_x_ext, w_y_ext, w_shifted, w_mask, w_y_al;
    logic          w_sticky;
    logic [SW-1:0] w_sum;

    assign w_x_ext   = {r1_x_man, 3'b000};
    assign w_y_ext   = {r1_y_man, 3'b000};
    assign w_shifted = w_y_ext >> r1_diff;
    assign w_mask    = (AW'(1) << r1_diff) - AW'(1);
    assign w_sticky  = |(w_y_ext & w_mask);
    assign w_y_al    = (r1_diff > EXP_W'(AW - 1)) ? {(AW-1)'(0), |r1_y_man}
                                                  : {w_shifted[AW-1:1], w_shifted[0] | w_sticky};
    // |X| >= |Y| so the difference never goes negative
    assign w_sum     = r1_op ? (SW'(w_x_ext) - SW'(w_y_al)) : (SW'(w_x_ext) + SW'(w_y_al));

    logic             r2_valid, r2_sign, r2_zero_sign, r2_special;
    logic [SW-1:0]    r2_sum;
    logic [EXP_W-1:0] r2_exp;
    logic [W-1:0]     r2_spec_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid     <= 1'b0;
            r2_sign      <= 1'b0;
            r2_zero_sign <= 1'b0;
            r2_special   <= 1'b0;
            r2_sum       <= '0;
            r2_exp       <= '0;
            r2_spec_val  <= '0;
        end else begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sign      <= r1_x_sign;
                r2_zero_sign <= r1_x_sign & ~r1_op;
                r2_special   <= r1_special;
                r2_sum       <= w_sum;
                r2_exp       <= r1_x_exp;
                r2_spec_val  <= r1_spec_val;
            end
        end
    end

    // ---------------- Stage 3: normalise, truncate, apply special cases
    logic [LZW-1:0]       w_lz;
    logic [AW-1:0]        w_norm;
    logic [MAN_W-1:0]     w_mant;
    logic signed [EW-1:0] w_exp_in, w_exp;
    logic [W-1:0]         w_res;

    always_comb begin
        w_lz = LZW'(AW);
        for (int i = 0; i < int'(AW); i++) begin
            if (r2_sum[i]) w_lz = LZW'(int'(AW) - 1 - i);
        end
    end

    assign w_norm   = r2_sum[AW-1:0] << w_lz;
    assign w_mant   = r2_sum[SW-1] ? MAN_W'(r2_sum >> 4) : MAN_W'(w_norm >> 3);
    assign w_exp_in = $signed({2'b00, r2_exp});
    assign w_exp    = r2_sum[SW-1] ? (w_exp_in + $signed(EW'(1)))
                                   : (w_exp_in - $signed(EW'(w_lz)));

    always_comb begin
        w_res = '0;
        if (r2_special)
            w_res = r2_spec_val;
        else if (r2_sum == '0)
            w_res = {r2_zero_sign, {(W-1){1'b0}}};
        else if (w_exp >= $signed(EW'(EMAX)))
            w_res = {r2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        else if (w_exp <= $signed(EW'(0)))
            w_res = {r2_sign, {(W-1){1'b0}}};
        else
            w_res = {r2_sign, w_exp[EXP_W-1:0], w_mant};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= r2_valid;
            if (r2_valid) sum <= w_res;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed and random checks of fp_addsub_pipe against hand-computed values and a real-valued RZ model.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic        sub;
    logic        out_valid;
    logic [31:0] sum;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .sum(sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, expv);
        end
    endtask

    // Normal single to double bit pattern
    function automatic logic [63:0] to_dbl(input logic [31:0] f);
        return {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    endfunction

    // Round-toward-zero reference; operands chosen so the double result is exact
    function automatic logic [31:0] ref_rz(input logic [31:0] fa, input logic [31:0] fb, input logic fs);
        real         ra, rb, r;
        logic [63:0] d;
        int          e;
        ra = $bitstoreal(to_dbl(fa));
        rb = $bitstoreal(to_dbl(fb));
        r  = fs ? (ra - rb) : (ra + rb);
        if (r == 0.0) return 32'h0000_0000;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    // One isolated operation: latency, result and hold after out_valid drops
    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic ts, input logic [31:0] texp);
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, sum, texp);
        @(posedge clk); #1;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_hold"}, sum, texp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          ea, eb;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_sum", sum, 32'h0);
        rst = 1'b0;

        run_one("one_plus_two",  32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
        run_one("two_plus_one",  32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h4040_0000);
        run_one("cancel_pos",    32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
        run_one("neg_zero_sum",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
        run_one("mixed_zero",    32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000);
        run_one("sticky_sub",    32'h3F80_0000, 32'h3080_0000, 1'b1, 32'h3F7F_FFFF);
        run_one("sticky_add",    32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000);
        run_one("ovf_pos",       32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF);
        run_one("ovf_neg",       32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'hFF7F_FFFF);
        run_one("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
        run_one("nan_in",        32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
        run_one("inf_plus_one",  32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000);
        run_one("one_minus_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000);
        run_one("denorm_in",     32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000);
        run_one("underflow",     32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000);
        run_one("sub_zero",      32'h3F80_0000, 32'h0000_0000, 1'b1, 32'h3F80_0000);
        run_one("norm_left",     32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000);

        // Back-to-back random normals with nearby exponents
        for (int i = 0; i < 102; i++) begin
            if (i < 100) begin
                ea = int'($urandom_range(64, 190));
                eb = ea + int'($urandom_range(0, 20)) - 10;
                ra = {1'($urandom), 8'(ea), 23'($urandom)};
                rb = {1'($urandom), 8'(eb), 23'($urandom)};
                if (i % 17 == 0) rb = {1'($urandom), ra[30:0]};
                rs = 1'($urandom);
                a = ra; b = rb; sub = rs; in_valid = 1'b1;
                exp_q.push_back(ref_rz(ra, rb, rs));
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= 2) begin
                check("rnd_valid", 32'(out_valid), 32'd1);
                check("rnd_sum", sum, exp_q.pop_front());
            end
        end
        @(posedge clk); #1;
        check("rnd_drain", 32'(out_valid), 32'd0);

        // Reset with two operations in flight and a third offered on the reset edge
        a = 32'h3F80_0000; b = 32'h4000_0000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h4000_0000; b = 32'h4000_0000;
        @(posedge clk); #1;
        rst = 1'b1; a = 32'h4040_0000;
        @(posedge clk); #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", sum, 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_stale", 32'(out_valid), 32'd0);
        end
        run_one("post_rst", 32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
